instr_loader: RTL
=================

# instr_loader

Boot-time instruction loader that drives the fetch stage's instruction-memory write port (`i_instruccion`, `i_address`, `i_loading` on the pipeline top). It takes a byte stream from the UART receiver, packs bytes into 32-bit words (MSB first), and writes each word to consecutive instruction addresses. The stream ends at a halt word, or with an overflow error when instruction memory is full. It sits between the UART RX block and the pipeline top; the pipeline stays in reset while `o_busy` is high.

## Interface
- `DATA_WIDTH`, 32, instruction/address width
- `MEM_DEPTH`, 64, instruction memory depth in words
- `HALT_WORD`, 32'hFFFF_FFFF, word that ends a load session
- `i_clock`  in  1  system clock, rising edge
- `i_reset`  in  1  one clock; reset is asynchronous and active-low
- `i_start`  in  1  one-cycle pulse that begins a new load session
- `i_rx_data`  in  8  received byte
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid this cycle
- `o_instruccion`  out  DATA_WIDTH  assembled word, goes to the fetch stage `i_instruccion`
- `o_address`  out  DATA_WIDTH  byte address of the word, goes to `i_address`
- `o_loading`  out  1  one-cycle write strobe, goes to `i_loading`
- `o_busy`  out  1  session in progress (RECV or WRITE)
- `o_done`  out  1  halt word written; held until next `i_start` or reset
- `o_overflow`  out  1  memory filled without halt word; held until next `i_start` or reset

## Operation
- State machine has four states: IDLE, RECV, WRITE, DONE, plus ERROR.
- IDLE: bytes are ignored. On `i_start`, go to RECV and clear the byte count (2-bit), the address, `o_done` and `o_overflow`.
- RECV and WRITE: each `i_rx_valid` shifts the byte into a 32-bit assembler (`asm <= {asm[23:0], byte}`) and increments the byte count mod 4.
  - When a byte arrives with count==3, latch `{asm[23:0], byte}` into `o_instruccion` and go to WRITE.
- WRITE lasts exactly one cycle, with `o_loading`=1 and `o_address` = current address. Next state:
  - if `o_instruccion`==HALT_WORD → DONE (the halt word itself is written);
  - else if the word index written == MEM_DEPTH-1 → ERROR;
  - else → RECV, with address += 4.
- A byte arriving during WRITE is accepted normally (it starts the next word).
- DONE: `o_done`=1. ERROR: `o_overflow`=1. Bytes are ignored in both states. `i_start` restarts a session from address 0.
- `i_start` during RECV/WRITE restarts the session: count=0, address=0. An in-flight WRITE cycle still completes its strobe.
- `i_start` together with `i_rx_valid`: the start wins and the byte is dropped.
- Address width rule: the address counts in bytes, steps by 4, and is zero-extended to DATA_WIDTH. It never exceeds (MEM_DEPTH-1)*4.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `o_instruccion`=0, `o_address`=0, `o_loading`=0, `o_busy`=0, `o_done`=0, `o_overflow`=0; assembler and count cleared.
- Reset is asynchronous. Asserting `i_reset` low mid-session aborts immediately and discards the partial word. No write strobe is produced during or after reset until a new `i_start`.
- Latency:
  - 4th byte strobe in cycle N → `o_loading`=1 in cycle N+1, with `o_instruccion`/`o_address` already valid in N+1.
  - `o_instruccion` and `o_address` hold until the next latch.
  - `o_done`/`o_overflow` rise in cycle N+2 and `o_busy` falls in N+2.
  - `i_start` in cycle M → `o_busy`=1 in M+1.
- Minimum byte spacing is one cycle, so back-to-back strobes are legal. Words are written at most once every 4 cycles.

## Test plan
- Single word: reset, `i_start`, bytes 0x20,0x01,0x00,0x05 → one `o_loading` pulse one cycle after the 4th byte, with `o_instruccion`=0x20010005 and `o_address`=0.
- Program with halt: words 0x8C220004, 0x00421820, 0xAC230008, 0xFFFFFFFF → four pulses at addresses 0,4,8,12. Then `o_done`=1 and `o_busy`=0; further bytes produce no pulse.
- Overflow (MEM_DEPTH=4): five non-halt words → four pulses at 0..12, then `o_overflow`=1. The 5th word is not written. `i_start` clears `o_overflow`.
- Reset mid-word: start, bytes 0xAA,0xBB, pull `i_reset` low for 2 cycles, start, bytes 0x11,0x22,0x33,0x44 → single pulse with 0x11223344 at address 0.
- Back-to-back bytes: 8 consecutive-cycle strobes 0x01..0x08 → pulses with 0x01020304 at 0 and 0x05060708 at 4. The 5th byte arrives during the WRITE cycle and is not lost.
- Pre-start and simultaneous start: bytes before `i_start` are ignored. `i_start` with `i_rx_valid`(0xEE) drops 0xEE, so the next four bytes form the first word.

Source files
------------

// File: rtl/instr_loader.sv
// Boot-time instruction loader: packs UART bytes MSB-first into words
// and writes them to consecutive instruction-memory addresses.
module instr_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 64,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t        state;
    logic [23:0]   asm_q;
    logic [1:0]    cnt;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic          last_idx;
    logic          accept;

    assign word     = {asm_q, i_rx_data};
    assign last_idx = (idx == AW'(MEM_DEPTH - 1));
    assign accept   = i_rx_valid && (state == RECV || state == WRITE);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            asm_q         <= '0;
            cnt           <= '0;
            idx           <= '0;
            o_instruccion <= '0;
            o_address     <= '0;
            o_loading     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_loading <= 1'b0;
            // A start outranks any byte in the same cycle; the byte is dropped.
            if (i_start) begin
                state      <= RECV;
                cnt        <= '0;
                idx        <= '0;
                o_busy     <= 1'b1;
                o_done     <= 1'b0;
                o_overflow <= 1'b0;
            end else begin
                if (accept) begin
                    asm_q <= word[23:0];
                    cnt   <= cnt + 2'd1;
                end
                case (state)
                    RECV: begin
                        if (i_rx_valid && cnt == 2'd3) begin
                            o_instruccion <= DATA_WIDTH'(word);
                            o_address     <= DATA_WIDTH'({idx, 2'b00});
                            o_loading     <= 1'b1;
                            state         <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (o_instruccion == HALT_WORD) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else if (last_idx) begin
                            state      <= ERROR;
                            o_busy     <= 1'b0;
                            o_overflow <= 1'b1;
                        end else begin
                            state <= RECV;
                            idx   <= idx + AW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
